// File: rtl/tft43_pixel_prefetch_if.sv
// Arbiter Read Port-1 bundle used by the TFT43 pixel prefetcher.
// master: the prefetcher (issues burst requests, receives 4-word bursts).
// slave:  the SDRAM read/write arbiter.
interface tft43_pixel_prefetch_if;
    logic        oRd_Req;
    logic [23:0] oRd_Addr;
    logic        iRd_Done;
    logic [15:0] iRd_Data1;
    logic [15:0] iRd_Data2;
    logic [15:0] iRd_Data3;
    logic [15:0] iRd_Data4;

    modport master (
        output oRd_Req,
        output oRd_Addr,
        input  iRd_Done,
        input  iRd_Data1,
        input  iRd_Data2,
        input  iRd_Data3,
        input  iRd_Data4
    );

    modport slave (
        input  oRd_Req,
        input  oRd_Addr,
        output iRd_Done,
        output iRd_Data1,
        output iRd_Data2,
        output iRd_Data3,
        output iRd_Data4
    );
endinterface

// File: rtl/tft43_pixel_prefetch.sv
// Frame-buffer prefetcher between the SDRAM arbiter (Read Port-1) and the
// TFT43 LCD timing generator. Issues 4-word bursts at linear addresses from
// a per-frame base, stages each burst, and pushes it into a first-word-
// fall-through FIFO that the display pops one word per pixel.
// Optional build macro: TFT43_PREFETCH_RB_SWAP_EN swaps the red and blue
// fields of the output word for BGR-wired panels.
module tft43_pixel_prefetch #(
    parameter int H_PIXELS   = 480,
    parameter int V_LINES    = 272,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        iFrame_Start,
    input  logic [23:0] iBase_Addr,
    input  logic        iPix_Rd,
    output logic [15:0] oPix_Data,
    output logic        oPix_Valid,
    output logic        oUnderflow,
    tft43_pixel_prefetch_if.master rdPort
);

    localparam int FRAME_WORDS = H_PIXELS * V_LINES;
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int CW          = AW + 1;
    localparam int FW          = $clog2(FRAME_WORDS + 1);

    // A burst is only requested when four free slots are guaranteed.
    localparam logic [CW-1:0] REQ_LIMIT   = CW'(FIFO_DEPTH - 4);
    localparam logic [FW-1:0] FRAME_TOTAL = FW'(FRAME_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        PUSH,
        DRAIN
    } stateT;

    stateT         stateQ, stateD;

    logic [23:0]   addrQ;
    logic [23:0]   rdAddrQ;
    logic [23:0]   pendingBaseQ;
    logic [23:0]   startBase;
    logic [FW-1:0] fetchedQ;
    logic [15:0]   stageQ [4];
    logic [1:0]    pushIdxQ;

    logic [15:0]   fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtrQ, rdPtrQ;
    logic [CW-1:0] countQ;
    logic          underflowQ;

    // Per-cycle control strobes decoded by the FSM.
    logic          applyStart;   // restart frame now: load base, flush FIFO, clear underflow
    logic          useLatched;   // restart uses the base captured during DRAIN
    logic          savePending;  // capture iBase_Addr for a deferred restart
    logic          loadReq;      // CHECK->REQ: register the burst address
    logic          captureEn;    // accept a completed burst into staging
    logic          pushEn;       // write one staged word into the FIFO

    logic          fifoEmpty;
    logic          doPush;
    logic          doPop;
    logic [15:0]   headWord;
    logic [15:0]   outWord;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every clocked block uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (!rst_n) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    // Next-state decode and control strobes.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        stateD      = stateQ;
        applyStart  = 1'b0;
        useLatched  = 1'b0;
        savePending = 1'b0;
        loadReq     = 1'b0;
        captureEn   = 1'b0;
        pushEn      = 1'b0;

        unique case (stateQ)
            IDLE: begin
                if (iFrame_Start) begin
                    applyStart = 1'b1;
                    stateD     = CHECK;
                end
            end
            CHECK: begin
                if (iFrame_Start) begin
                    applyStart = 1'b1;
                    stateD     = CHECK;
                end else if (fetchedQ == FRAME_TOTAL) begin
                    stateD = IDLE;
                end else if (en && (countQ <= REQ_LIMIT)) begin
                    loadReq = 1'b1;
                    stateD  = REQ;
                end
            end
            REQ: begin
                if (iFrame_Start && rdPort.iRd_Done) begin
                    // Transaction completes in the same cycle: drop its data
                    // and restart at once with the new base.
                    applyStart = 1'b1;
                    stateD     = CHECK;
                end else if (iFrame_Start) begin
                    savePending = 1'b1;
                    stateD      = DRAIN;
                end else if (rdPort.iRd_Done) begin
                    captureEn = 1'b1;
                    stateD    = PUSH;
                end
            end
            PUSH: begin
                if (iFrame_Start) begin
                    applyStart = 1'b1;
                    stateD     = CHECK;
                end else begin
                    pushEn = 1'b1;
                    if (pushIdxQ == 2'd3) stateD = CHECK;
                end
            end
            DRAIN: begin
                if (rdPort.iRd_Done) begin
                    applyStart = 1'b1;
                    useLatched = !iFrame_Start;
                    stateD     = CHECK;
                end else if (iFrame_Start) begin
                    savePending = 1'b1;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    assign startBase          = useLatched ? pendingBaseQ : iBase_Addr;
    assign rdPort.oRd_Req     = (stateQ == REQ) || (stateQ == DRAIN);
    assign rdPort.oRd_Addr    = rdAddrQ;

    // Frame address, fetch progress, request address and push sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrQ        <= '0;
            fetchedQ     <= '0;
            rdAddrQ      <= '0;
            pendingBaseQ <= '0;
            pushIdxQ     <= '0;
        end else begin
            if (applyStart) begin
                addrQ    <= startBase;
                fetchedQ <= '0;
            end else if (captureEn) begin
                addrQ    <= addrQ + 24'd4;
                fetchedQ <= fetchedQ + FW'(4);
            end

            if (loadReq)     rdAddrQ      <= addrQ;
            if (savePending) pendingBaseQ <= iBase_Addr;

            if (captureEn)   pushIdxQ <= '0;
            else if (pushEn) pushIdxQ <= pushIdxQ + 2'd1;
        end
    end

    // Burst staging register, loaded when the arbiter signals done.
    always_ff @(posedge clk) begin
        if (captureEn) begin
            stageQ[0] <= rdPort.iRd_Data1;
            stageQ[1] <= rdPort.iRd_Data2;
            stageQ[2] <= rdPort.iRd_Data3;
            stageQ[3] <= rdPort.iRd_Data4;
        end
    end

    assign fifoEmpty = (countQ == '0);
    assign doPush    = pushEn;
    assign doPop     = iPix_Rd && !fifoEmpty && !applyStart;

    // FIFO storage array.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; validity is tracked by
        // the pointers and count, so stale contents are never observed.
        if (doPush) fifoMem[wrPtrQ] <= stageQ[pushIdxQ];
    end

    // FIFO pointers and occupancy; a frame restart flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else if (applyStart) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (doPush) wrPtrQ <= wrPtrQ + AW'(1);
            if (doPop)  rdPtrQ <= rdPtrQ + AW'(1);
            case ({doPush, doPop})
                2'b10:   countQ <= countQ + CW'(1);
                2'b01:   countQ <= countQ - CW'(1);
                default: countQ <= countQ;
            endcase
        end
    end

    // Sticky underflow: set by a pop on an empty FIFO, cleared by a restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      underflowQ <= 1'b0;
        else if (applyStart)             underflowQ <= 1'b0;
        else if (iPix_Rd && fifoEmpty)   underflowQ <= 1'b1;
    end

    assign headWord = fifoMem[rdPtrQ];

`ifdef TFT43_PREFETCH_RB_SWAP_EN
    assign outWord = {headWord[4:0], headWord[10:5], headWord[15:11]};
`else
    assign outWord = headWord;
`endif

    assign oPix_Valid = !fifoEmpty;
    assign oPix_Data  = fifoEmpty ? 16'h0000 : outWord;
    assign oUnderflow = underflowQ;

endmodule

// File: tb/tb_tft43_pixel_prefetch.sv
// Self-checking bench for tft43_pixel_prefetch. A full-size instance covers
// fetch sequencing, FIFO behaviour, underflow, restart and enable gating; an
// 8x2 instance covers a complete frame. Expected pixel streams come from a
// queue of the words the arbiter model returned.
module tb_tft43_pixel_prefetch;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Full-size instance.
    logic        en, frameStart, pixRd;
    logic [23:0] baseAddr;
    logic [15:0] pixData;
    logic        pixValid, underflow;
    tft43_pixel_prefetch_if bigBus();

    tft43_pixel_prefetch #(.H_PIXELS(480), .V_LINES(272), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .iFrame_Start(frameStart),
        .iBase_Addr(baseAddr), .iPix_Rd(pixRd), .oPix_Data(pixData),
        .oPix_Valid(pixValid), .oUnderflow(underflow), .rdPort(bigBus)
    );

    // 8x2 instance: one frame is 16 words, four bursts.
    logic        sEn, sFrameStart, sPixRd;
    logic [23:0] sBase;
    logic [15:0] sPixData;
    logic        sPixValid, sUnderflow;
    tft43_pixel_prefetch_if smallBus();

    tft43_pixel_prefetch #(.H_PIXELS(8), .V_LINES(2), .FIFO_DEPTH(DEPTH)) dutSmall (
        .clk(clk), .rst_n(rst_n), .en(sEn), .iFrame_Start(sFrameStart),
        .iBase_Addr(sBase), .iPix_Rd(sPixRd), .oPix_Data(sPixData),
        .oPix_Valid(sPixValid), .oUnderflow(sUnderflow), .rdPort(smallBus)
    );

    // Output word the display should see for a stored word.
    function automatic logic [15:0] expPix(input logic [15:0] w);
`ifdef TFT43_PREFETCH_RB_SWAP_EN
        return {w[4:0], w[10:5], w[15:11]};
`else
        return w;
`endif
    endfunction

    // Autonomous arbiter model for the full-size instance: done arrives
    // arbLat cycles after the request is seen; returned words are queued.
    bit          arbOn = 1'b0;
    bit          arbBusy = 1'b0;
    int          arbLat = 6;
    logic [23:0] reqLog [$];
    logic [15:0] expQ [$];

    initial begin
        logic [15:0] w [4];
        bigBus.iRd_Done = 1'b0;
        bigBus.iRd_Data1 = '0; bigBus.iRd_Data2 = '0;
        bigBus.iRd_Data3 = '0; bigBus.iRd_Data4 = '0;
        forever begin
            @(negedge clk);
            if (arbOn && bigBus.oRd_Req) begin
                arbBusy = 1'b1;
                reqLog.push_back(bigBus.oRd_Addr);
                repeat (arbLat - 1) @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    w[k] = 16'($urandom);
                    expQ.push_back(w[k]);
                end
                bigBus.iRd_Data1 = w[0]; bigBus.iRd_Data2 = w[1];
                bigBus.iRd_Data3 = w[2]; bigBus.iRd_Data4 = w[3];
                bigBus.iRd_Done = 1'b1;
                @(negedge clk);
                bigBus.iRd_Done = 1'b0;
                arbBusy = 1'b0;
            end
        end
    end

    initial begin
        smallBus.iRd_Done = 1'b0;
        smallBus.iRd_Data1 = '0; smallBus.iRd_Data2 = '0;
        smallBus.iRd_Data3 = '0; smallBus.iRd_Data4 = '0;
    end

    task automatic doReset();
        arbOn = 1'b0;
        en = 1'b0; frameStart = 1'b0; baseAddr = '0; pixRd = 1'b0;
        sEn = 1'b0; sFrameStart = 1'b0; sBase = '0; sPixRd = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reqLog.delete();
        expQ.delete();
    endtask

    // Pulse iFrame_Start for one cycle; returns just after the sampling edge.
    task automatic pulseStart(input logic [23:0] base);
        baseAddr = base;
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
    endtask

    // Manual arbiter response on the full-size instance.
    task automatic bigDone(input logic [15:0] w0, w1, w2, w3);
        bigBus.iRd_Data1 = w0; bigBus.iRd_Data2 = w1;
        bigBus.iRd_Data3 = w2; bigBus.iRd_Data4 = w3;
        bigBus.iRd_Done = 1'b1;
        @(negedge clk);
        bigBus.iRd_Done = 1'b0;
    endtask

    task automatic waitReq(input string tag);
        for (int i = 0; i < 200 && !bigBus.oRd_Req; i++) @(negedge clk);
        if (!bigBus.oRd_Req) begin
            checks++; errors++;
            $display("FAIL %s: request timeout, oRd_Req got 0 expected 1", tag);
        end
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (bigBus.oRd_Req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bigBus.oRd_Req); end
        checks++; if (bigBus.oRd_Addr !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h expected 000000", bigBus.oRd_Addr); end
        checks++; if (pixValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pixValid); end
        checks++; if (pixData !== 16'h0) begin errors++; $display("FAIL reset_data: got %h expected 0000", pixData); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    endtask

    task automatic test_basic_fetch();
        logic [23:0] ea;
        doReset();
        en = 1'b1; arbLat = 6; arbOn = 1'b1;
        pulseStart(24'h000100);
        checks++; if (bigBus.oRd_Req !== 1'b0) begin errors++; $display("FAIL start_lat1: got %b expected 0", bigBus.oRd_Req); end
        @(negedge clk);
        checks++; if (bigBus.oRd_Req !== 1'b1) begin errors++; $display("FAIL start_lat2: got %b expected 1", bigBus.oRd_Req); end
        repeat (260) @(negedge clk);
        checks++; if (reqLog.size() != 16) begin errors++; $display("FAIL fill_requests: got %0d expected 16", reqLog.size()); end
        for (int i = 0; i < reqLog.size(); i++) begin
            ea = 24'h000100 + 24'(4 * i);
            checks++; if (reqLog[i] !== ea) begin errors++; $display("FAIL fill_addr[%0d]: got %h expected %h", i, reqLog[i], ea); end
        end
        checks++; if (bigBus.oRd_Req !== 1'b0) begin errors++; $display("FAIL fill_stop: got %b expected 0", bigBus.oRd_Req); end
        checks++; if (pixValid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b expected 1", pixValid); end
        if (expQ.size() > 0) begin
            checks++; if (pixData !== expPix(expQ[0])) begin errors++; $display("FAIL fill_head: got %h expected %h", pixData, expPix(expQ[0])); end
        end
    endtask

    // Continues the frame from test_basic_fetch: pops overlap burst pushes.
    task automatic test_push_pop();
        logic [15:0] ew;
        int n, drained;
        for (int c = 0; c < 400; c++) begin
            pixRd = (c < 150) ? 1'b1 : ($urandom_range(0, 99) < 30);
            if (pixRd && pixValid) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("FAIL pop_order: got %h expected no word", pixData);
                end else begin
                    ew = expPix(expQ.pop_front());
                    if (pixData !== ew) begin errors++; $display("FAIL pop_order: got %h expected %h", pixData, ew); end
                end
            end
            @(negedge clk);
        end
        pixRd = 1'b0;
        arbOn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 50 && arbBusy; i++) @(negedge clk);
        checks++; if (arbBusy) begin errors++; $display("FAIL arb_idle: got busy expected idle"); end
        repeat (8) @(negedge clk);
        n = expQ.size();
        drained = 0;
        for (int i = 0; i < 100 && pixValid; i++) begin
            pixRd = 1'b1;
            checks++;
            if (expQ.size() == 0) begin
                errors++; $display("FAIL drain_order: got %h expected no word", pixData);
            end else begin
                ew = expPix(expQ.pop_front());
                if (pixData !== ew) begin errors++; $display("FAIL drain_order: got %h expected %h", pixData, ew); end
            end
            drained++;
            @(negedge clk);
        end
        pixRd = 1'b0;
        checks++; if (drained != n) begin errors++; $display("FAIL drain_count: got %0d expected %0d", drained, n); end
    endtask

    task automatic test_underflow();
        doReset();
        en = 1'b1;
        pulseStart(24'h000000);
        waitReq("underflow_req");
        pixRd = 1'b1;
        @(negedge clk);
        pixRd = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b expected 1", underflow); end
        checks++; if (pixValid !== 1'b0) begin errors++; $display("FAIL underflow_valid: got %b expected 0", pixValid); end
        repeat (3) @(negedge clk);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b expected 1", underflow); end
        bigDone(16'hF800, 16'($urandom), 16'($urandom), 16'($urandom));
        checks++; if (bigBus.oRd_Req !== 1'b0) begin errors++; $display("FAIL done_req_low: got %b expected 0", bigBus.oRd_Req); end
        checks++; if (pixValid !== 1'b0) begin errors++; $display("FAIL done_lat1: got %b expected 0", pixValid); end
        @(negedge clk);
        checks++; if (pixValid !== 1'b1) begin errors++; $display("FAIL done_lat2: got %b expected 1", pixValid); end
        checks++; if (pixData !== expPix(16'hF800)) begin errors++; $display("FAIL first_word: got %h expected %h", pixData, expPix(16'hF800)); end
        pulseStart(24'h000040);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b expected 0", underflow); end
        checks++; if (pixValid !== 1'b0) begin errors++; $display("FAIL restart_flush: got %b expected 0", pixValid); end
    endtask

    task automatic test_restart();
        doReset();
        en = 1'b1;
        pulseStart(24'h0001FC);
        waitReq("restart_req0");
        checks++; if (bigBus.oRd_Addr !== 24'h0001FC) begin errors++; $display("FAIL restart_addr0: got %h expected 0001fc", bigBus.oRd_Addr); end
        bigDone(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        waitReq("restart_req1");
        checks++; if (bigBus.oRd_Addr !== 24'h000200) begin errors++; $display("FAIL restart_addr1: got %h expected 000200", bigBus.oRd_Addr); end
        pulseStart(24'h000800);
        repeat (3) @(negedge clk);
        checks++; if (bigBus.oRd_Req !== 1'b1) begin errors++; $display("FAIL drain_hold: got %b expected 1", bigBus.oRd_Req); end
        checks++; if (bigBus.oRd_Addr !== 24'h000200) begin errors++; $display("FAIL drain_addr: got %h expected 000200", bigBus.oRd_Addr); end
        checks++; if (pixValid !== 1'b1) begin errors++; $display("FAIL drain_fifo: got %b expected 1", pixValid); end
        bigDone(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        checks++; if (bigBus.oRd_Req !== 1'b0) begin errors++; $display("FAIL drain_drop: got %b expected 0", bigBus.oRd_Req); end
        checks++; if (pixValid !== 1'b0) begin errors++; $display("FAIL drain_flush: got %b expected 0", pixValid); end
        @(negedge clk);
        checks++; if (bigBus.oRd_Req !== 1'b1) begin errors++; $display("FAIL newbase_req: got %b expected 1", bigBus.oRd_Req); end
        checks++; if (bigBus.oRd_Addr !== 24'h000800) begin errors++; $display("FAIL newbase_addr: got %h expected 000800", bigBus.oRd_Addr); end
        checks++; if (pixValid !== 1'b0) begin errors++; $display("FAIL newbase_empty: got %b expected 0", pixValid); end
    endtask

    task automatic test_en_gating();
        logic [23:0] base;
        int hi;
        doReset();
        base = 24'($urandom) & 24'hFFFFFC;
        en = 1'b0;
        pulseStart(base);
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            if (bigBus.oRd_Req) hi++;
            @(negedge clk);
        end
        checks++; if (hi != 0) begin errors++; $display("FAIL en_block: got %0d request cycles expected 0", hi); end
        en = 1'b1;
        @(negedge clk);
        checks++; if (bigBus.oRd_Req !== 1'b1) begin errors++; $display("FAIL en_release: got %b expected 1", bigBus.oRd_Req); end
        checks++; if (bigBus.oRd_Addr !== base) begin errors++; $display("FAIL en_addr: got %h expected %h", bigBus.oRd_Addr, base); end
    endtask

    task automatic test_full_frame();
        logic [23:0] base, ea;
        logic [15:0] sq [$];
        logic [15:0] w [4];
        logic [15:0] ew;
        int reqs, pops, lat;
        bit busy;
        doReset();
        reqs = 0; pops = 0; lat = 0; busy = 1'b0;
        base = 24'($urandom) & 24'hFFFFFC;
        sEn = 1'b1; sPixRd = 1'b1; sBase = base;
        sFrameStart = 1'b1;
        @(negedge clk);
        sFrameStart = 1'b0;
        for (int c = 0; c < 200; c++) begin
            smallBus.iRd_Done = 1'b0;
            if (sPixValid) begin
                pops++;
                checks++;
                if (sq.size() == 0) begin
                    errors++; $display("FAIL frame_word: got %h expected no word", sPixData);
                end else begin
                    ew = expPix(sq.pop_front());
                    if (sPixData !== ew) begin errors++; $display("FAIL frame_word: got %h expected %h", sPixData, ew); end
                end
            end
            if (busy) begin
                lat--;
                if (lat == 0) begin
                    busy = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        w[k] = 16'($urandom);
                        sq.push_back(w[k]);
                    end
                    smallBus.iRd_Data1 = w[0]; smallBus.iRd_Data2 = w[1];
                    smallBus.iRd_Data3 = w[2]; smallBus.iRd_Data4 = w[3];
                    smallBus.iRd_Done = 1'b1;
                end
            end else if (smallBus.oRd_Req) begin
                reqs++;
                ea = base + 24'(4 * (reqs - 1));
                checks++; if (smallBus.oRd_Addr !== ea) begin errors++; $display("FAIL frame_addr: got %h expected %h", smallBus.oRd_Addr, ea); end
                busy = 1'b1;
                lat = 3;
            end
            @(negedge clk);
        end
        smallBus.iRd_Done = 1'b0;
        sPixRd = 1'b0;
        checks++; if (reqs != 4) begin errors++; $display("FAIL frame_requests: got %0d expected 4", reqs); end
        checks++; if (pops != 16) begin errors++; $display("FAIL frame_pops: got %0d expected 16", pops); end
        checks++; if (smallBus.oRd_Req !== 1'b0) begin errors++; $display("FAIL frame_idle: got %b expected 0", smallBus.oRd_Req); end
        checks++; if (sPixValid !== 1'b0) begin errors++; $display("FAIL frame_empty: got %b expected 0", sPixValid); end
        checks++; if (sUnderflow !== 1'b1) begin errors++; $display("FAIL frame_underflow: got %b expected 1", sUnderflow); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_push_pop();
        test_underflow();
        test_restart();
        test_en_gating();
        test_full_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
